// File: rtl/pulse_sweep_ctrl.sv
// rtl/pulse_sweep_ctrl.sv - shadow/live pulse parameter bank with shot-aligned commit and delay sweep sequencer (optional SWEEP_NUT_EN: nut_d sweep)
module pulse_sweep_ctrl #(
   parameter int AW = 4,
   parameter int DW = 32
) (
   input  logic          clk_pll,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          commit,
   input  logic          start,
   input  logic          abort,
   input  logic          sync_on,
   output logic [7:0]    per,
   output logic [7:0]    cp,
   output logic [7:0]    p_bl,
   output logic [15:0]   p1wid,
   output logic [15:0]   del,
   output logic [15:0]   p2wid,
   output logic [15:0]   p_bl_off,
   output logic [31:0]   nut_w,
   output logic [31:0]   nut_d,
   output logic          pu,
   output logic          bl,
   output logic          nut,
   output logic          busy,
   output logic          done,
   output logic          acq_valid,
   output logic [15:0]   step_idx,
   output logic          ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Shadow bank, written only by the UART decoder
   logic [7:0]  sh_per, sh_cp, sh_p_bl;
   logic [15:0] sh_p1wid, sh_del, sh_p2wid, sh_p_bl_off;
   logic [31:0] sh_nut_w, sh_nut_d;
   logic [2:0]  sh_flags;
   logic [15:0] sh_del_step, sh_n_avg, sh_n_steps;
`ifdef SWEEP_NUT_EN
   logic [31:0] sh_nut_step;
`endif

   // Sequencer state and per-sweep snapshots
   state_t      state;
   logic        sync_q;
   logic        commit_pend;
   logic        settling;
   logic [15:0] shot_cnt;
   logic [15:0] base_del;
   logic [15:0] run_step;
   logic [15:0] run_navg_m1;
   logic [15:0] run_nsteps;
`ifdef SWEEP_NUT_EN
   logic [31:0] base_nut;
   logic [31:0] run_nut_step;
   logic [32:0] nut_sum;
`endif

   logic        sync_rise;
   logic        copy_live;
   logic        finish_run;
   logic [16:0] del_sum;

   // Shot edge detect, shadow->live copy request, sweep termination and next-delay sum
   always_comb begin
      sync_rise  = sync_on & ~sync_q;
      copy_live  = sync_rise &&
                   (((state == S_IDLE) && commit_pend && !start) ||
                    ((state == S_ARM) && !abort));
      finish_run = abort ||
                   (sync_rise && !settling && (shot_cnt == run_navg_m1) &&
                    (step_idx == run_nsteps));
      del_sum    = {1'b0, del} + {1'b0, run_step};
`ifdef SWEEP_NUT_EN
      nut_sum    = {1'b0, nut_d} + {1'b0, run_nut_step};
`endif
   end

   // Shadow register writes; unmapped addresses are dropped
   always_ff @(posedge clk_pll) begin
      if (!reset) begin
         sh_per      <= 8'd1;
         sh_p1wid    <= 16'd30;
         sh_del      <= 16'd200;
         sh_p2wid    <= 16'd30;
         sh_nut_w    <= 32'd50;
         sh_nut_d    <= 32'd300;
         sh_cp       <= 8'd1;
         sh_p_bl     <= 8'd50;
         sh_p_bl_off <= 16'd100;
         sh_flags    <= 3'b011;
         sh_del_step <= 16'd0;
         sh_n_avg    <= 16'd1;
         sh_n_steps  <= 16'd0;
`ifdef SWEEP_NUT_EN
         sh_nut_step <= 32'd0;
`endif
      end else if (wr_en) begin
         case (wr_addr)
            AW'(0):  sh_per      <= wr_data[7:0];
            AW'(1):  sh_p1wid    <= wr_data[15:0];
            AW'(2):  sh_del      <= wr_data[15:0];
            AW'(3):  sh_p2wid    <= wr_data[15:0];
            AW'(4):  sh_nut_w    <= wr_data[31:0];
            AW'(5):  sh_nut_d    <= wr_data[31:0];
            AW'(6):  sh_cp       <= wr_data[7:0];
            AW'(7):  sh_p_bl     <= wr_data[7:0];
            AW'(8):  sh_p_bl_off <= wr_data[15:0];
            AW'(9):  sh_flags    <= wr_data[2:0];
            AW'(10): sh_del_step <= wr_data[15:0];
            AW'(11): sh_n_avg    <= wr_data[15:0];
            AW'(12): sh_n_steps  <= wr_data[15:0];
`ifdef SWEEP_NUT_EN
            AW'(13): sh_nut_step <= wr_data[31:0];
`endif
            default: ;
         endcase
      end
   end

   // Sequencer FSM owning the live parameters and all status outputs
   always_ff @(posedge clk_pll) begin
      if (!reset) begin
         state       <= S_IDLE;
         sync_q      <= 1'b0;
         commit_pend <= 1'b0;
         settling    <= 1'b0;
         shot_cnt    <= 16'd0;
         base_del    <= 16'd200;
         run_step    <= 16'd0;
         run_navg_m1 <= 16'd0;
         run_nsteps  <= 16'd0;
`ifdef SWEEP_NUT_EN
         base_nut     <= 32'd300;
         run_nut_step <= 32'd0;
`endif
         per       <= 8'd1;
         p1wid     <= 16'd30;
         del       <= 16'd200;
         p2wid     <= 16'd30;
         nut_w     <= 32'd50;
         nut_d     <= 32'd300;
         cp        <= 8'd1;
         p_bl      <= 8'd50;
         p_bl_off  <= 16'd100;
         pu        <= 1'b1;
         bl        <= 1'b1;
         nut       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         acq_valid <= 1'b0;
         step_idx  <= 16'd0;
         ovf       <= 1'b0;
      end else begin
         sync_q <= sync_on;
         done   <= 1'b0;

         // Shot-aligned copy; later assignments in the case below take priority
         if (copy_live) begin
            per      <= sh_per;
            p1wid    <= sh_p1wid;
            del      <= sh_del;
            p2wid    <= sh_p2wid;
            nut_w    <= sh_nut_w;
            nut_d    <= sh_nut_d;
            cp       <= sh_cp;
            p_bl     <= sh_p_bl;
            p_bl_off <= sh_p_bl_off;
            pu       <= sh_flags[0];
            bl       <= sh_flags[1];
            nut      <= sh_flags[2];
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  // Start always copies the shadow bank, so a pending commit is redundant
                  state       <= S_ARM;
                  busy        <= 1'b1;
                  ovf         <= 1'b0;
                  step_idx    <= 16'd0;
                  shot_cnt    <= 16'd0;
                  settling    <= 1'b1;
                  acq_valid   <= 1'b0;
                  commit_pend <= 1'b0;
                  base_del    <= sh_del;
                  run_step    <= sh_del_step;
                  run_navg_m1 <= (sh_n_avg == 16'd0) ? 16'd0 : sh_n_avg - 16'd1;
                  run_nsteps  <= sh_n_steps;
`ifdef SWEEP_NUT_EN
                  base_nut     <= sh_nut_d;
                  run_nut_step <= sh_nut_step;
`endif
               end else if (commit) begin
                  commit_pend <= 1'b1;
               end else if (sync_rise) begin
                  commit_pend <= 1'b0;
               end
            end

            S_ARM: begin
               if (commit) commit_pend <= 1'b1;
               if (abort) begin
                  // Live bank not yet touched by this sweep, nothing to restore
                  state     <= S_DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  acq_valid <= 1'b0;
               end else if (sync_rise) begin
                  // The shot that starts now runs on fresh params and is a settle shot
                  state    <= S_RUN;
                  settling <= 1'b1;
               end
            end

            S_RUN: begin
               if (commit) commit_pend <= 1'b1;
               if (finish_run) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  acq_valid <= 1'b0;
                  del       <= base_del;
`ifdef SWEEP_NUT_EN
                  nut_d     <= base_nut;
`endif
               end else if (sync_rise) begin
                  if (settling) begin
                     settling  <= 1'b0;
                     acq_valid <= 1'b1;
                     shot_cnt  <= 16'd0;
                  end else if (shot_cnt == run_navg_m1) begin
                     step_idx  <= step_idx + 16'd1;
                     shot_cnt  <= 16'd0;
                     settling  <= 1'b1;
                     acq_valid <= 1'b0;
                     if (del_sum[16]) begin
                        del <= 16'hFFFF;
                        ovf <= 1'b1;
                     end else begin
                        del <= del_sum[15:0];
                     end
`ifdef SWEEP_NUT_EN
                     if (nut_sum[32]) begin
                        nut_d <= 32'hFFFF_FFFF;
                        ovf   <= 1'b1;
                     end else begin
                        nut_d <= nut_sum[31:0];
                     end
`endif
                  end else begin
                     shot_cnt <= shot_cnt + 16'd1;
                  end
               end
            end

            S_DONE: begin
               if (commit) commit_pend <= 1'b1;
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_sweep_ctrl.sv
// tb/tb_pulse_sweep_ctrl.sv - directed self-checking bench for pulse_sweep_ctrl
`timescale 1ns/1ps
module tb_pulse_sweep_ctrl;

   logic        clk_pll;
   logic        reset;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        commit, start, abort, sync_on;
   logic [7:0]  per, cp, p_bl;
   logic [15:0] p1wid, del, p2wid, p_bl_off;
   logic [31:0] nut_w, nut_d;
   logic        pu, bl, nut;
   logic        busy, done, acq_valid, ovf;
   logic [15:0] step_idx;

   int checks = 0;
   int errors = 0;

   pulse_sweep_ctrl #(.AW(4), .DW(32)) dut (
      .clk_pll(clk_pll), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .start(start), .abort(abort), .sync_on(sync_on),
      .per(per), .cp(cp), .p_bl(p_bl),
      .p1wid(p1wid), .del(del), .p2wid(p2wid), .p_bl_off(p_bl_off),
      .nut_w(nut_w), .nut_d(nut_d),
      .pu(pu), .bl(bl), .nut(nut),
      .busy(busy), .done(done), .acq_valid(acq_valid),
      .step_idx(step_idx), .ovf(ovf)
   );

   initial clk_pll = 1'b0;
   always #2.5 clk_pll = ~clk_pll;

   task automatic tick();
      @(posedge clk_pll);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pulse_commit();
      commit = 1'b1; tick(); commit = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   // Shot start: outputs reflect the sync_rise edge when this returns
   task automatic rise();
      sync_on = 1'b1; tick(); sync_on = 1'b0;
   endtask

   task automatic gap();
      repeat (5) tick();
   endtask

   task automatic test_reset();
      reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      commit = 1'b0; start = 1'b0; abort = 1'b0; sync_on = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      checks++; if (del !== 16'd200) begin errors++; $display("FAIL reset_del got %0d exp 200", del); end
      checks++; if ({per, cp, p_bl} !== {8'd1, 8'd1, 8'd50}) begin errors++; $display("FAIL reset_8b got %h exp 010132", {per, cp, p_bl}); end
      checks++; if ({p1wid, p2wid, p_bl_off} !== {16'd30, 16'd30, 16'd100}) begin errors++; $display("FAIL reset_16b got %h", {p1wid, p2wid, p_bl_off}); end
      checks++; if ({nut_w, nut_d} !== {32'd50, 32'd300}) begin errors++; $display("FAIL reset_nut got %0d %0d exp 50 300", nut_w, nut_d); end
      checks++; if ({nut, bl, pu} !== 3'b011) begin errors++; $display("FAIL reset_flags got %b exp 011", {nut, bl, pu}); end
      checks++; if ({busy, done, acq_valid, ovf} !== 4'b0000 || step_idx !== 16'd0) begin errors++; $display("FAIL reset_status got %b idx %0d exp 0000 idx 0", {busy, done, acq_valid, ovf}, step_idx); end
   endtask

   task automatic test_shadow_commit();
      wr(4'd2, 32'd400);
      for (int i = 0; i < 3; i++) begin
         rise();
         checks++; if (del !== 16'd200) begin errors++; $display("FAIL nocommit_del shot %0d got %0d exp 200", i, del); end
         gap();
      end
      pulse_commit();
      checks++; if (del !== 16'd200) begin errors++; $display("FAIL commit_before_shot got %0d exp 200", del); end
      rise();
      checks++; if (del !== 16'd400) begin errors++; $display("FAIL commit_applied got %0d exp 400", del); end
      gap();
      wr(4'd2, 32'd200);
      pulse_commit();
      rise(); gap();
      checks++; if (del !== 16'd200) begin errors++; $display("FAIL commit_back got %0d exp 200", del); end
   endtask

   task automatic test_sweep();
      wr(4'd10, 32'd100);
      wr(4'd11, 32'd2);
      wr(4'd12, 32'd2);
      pulse_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy got %b exp 1", busy); end
      for (int p = 0; p < 3; p++) begin
         for (int s = 0; s < 3; s++) begin
            rise();
            checks++; if (del !== 16'(200 + 100 * p)) begin errors++; $display("FAIL sweep_del p%0d s%0d got %0d exp %0d", p, s, del, 200 + 100 * p); end
            checks++; if (acq_valid !== (s != 0)) begin errors++; $display("FAIL sweep_acq p%0d s%0d got %b exp %b", p, s, acq_valid, s != 0); end
            checks++; if (step_idx !== 16'(p)) begin errors++; $display("FAIL sweep_idx p%0d s%0d got %0d exp %0d", p, s, step_idx, p); end
            gap();
         end
      end
      rise();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL sweep_done got %b exp 1", done); end
      checks++; if ({busy, acq_valid} !== 2'b00) begin errors++; $display("FAIL sweep_end_status got %b exp 00", {busy, acq_valid}); end
      checks++; if (del !== 16'd200) begin errors++; $display("FAIL sweep_restore got %0d exp 200", del); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL sweep_done_width got %b exp 0", done); end
      gap();
   endtask

   task automatic test_ovf();
      wr(4'd2, 32'hFFC0);
      wr(4'd10, 32'h80);
      wr(4'd11, 32'd1);
      wr(4'd12, 32'd1);
      pulse_start();
      rise(); gap();
      checks++; if (del !== 16'hFFC0) begin errors++; $display("FAIL ovf_p0_del got %h exp ffc0", del); end
      rise(); gap();
      rise();
      checks++; if (del !== 16'hFFFF) begin errors++; $display("FAIL ovf_sat_del got %h exp ffff", del); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf); end
      gap();
      rise(); gap();
      rise();
      checks++; if (done !== 1'b1 || del !== 16'hFFC0) begin errors++; $display("FAIL ovf_complete done %b del %h exp 1 ffc0", done, del); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
      gap();
      wr(4'd2, 32'd200);
   endtask

   task automatic test_abort();
      wr(4'd10, 32'd100);
      wr(4'd11, 32'd2);
      wr(4'd12, 32'd2);
      pulse_start();
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf_clear got %b exp 0", ovf); end
      for (int i = 0; i < 5; i++) begin rise(); gap(); end
      checks++; if (del !== 16'd300 || step_idx !== 16'd1 || acq_valid !== 1'b1) begin errors++; $display("FAIL abort_pre del %0d idx %0d acq %b exp 300 1 1", del, step_idx, acq_valid); end
      abort = 1'b1; tick(); abort = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_done done %b busy %b exp 1 0", done, busy); end
      checks++; if (del !== 16'd200 || acq_valid !== 1'b0) begin errors++; $display("FAIL abort_restore del %0d acq %b exp 200 0", del, acq_valid); end
      gap();
   endtask

   task automatic test_commit_busy();
      wr(4'd11, 32'd1);
      wr(4'd12, 32'd0);
      pulse_start();
      rise(); gap();
      wr(4'd1, 32'd60);
      pulse_commit();
      rise();
      checks++; if (p1wid !== 16'd30 || acq_valid !== 1'b1) begin errors++; $display("FAIL cbusy_run p1wid %0d acq %b exp 30 1", p1wid, acq_valid); end
      gap();
      rise();
      checks++; if (done !== 1'b1 || p1wid !== 16'd30) begin errors++; $display("FAIL cbusy_done done %b p1wid %0d exp 1 30", done, p1wid); end
      gap();
      rise();
      checks++; if (p1wid !== 16'd60) begin errors++; $display("FAIL cbusy_applied got %0d exp 60", p1wid); end
      gap();
   endtask

   task automatic test_nut_sweep();
      logic [31:0] inc;
`ifdef SWEEP_NUT_EN
      inc = 32'd10;
`else
      inc = 32'd0;
`endif
      wr(4'd13, 32'd10);
      wr(4'd10, 32'd0);
      wr(4'd11, 32'd1);
      wr(4'd12, 32'd3);
      pulse_start();
      for (int p = 0; p < 4; p++) begin
         rise();
         checks++; if (nut_d !== 32'd300 + inc * 32'(p)) begin errors++; $display("FAIL nut_point p%0d got %0d exp %0d", p, nut_d, 32'd300 + inc * 32'(p)); end
         gap();
         rise(); gap();
      end
      rise();
      checks++; if (done !== 1'b1 || nut_d !== 32'd300) begin errors++; $display("FAIL nut_restore done %b nut_d %0d exp 1 300", done, nut_d); end
      gap();
   endtask

   initial begin
      test_reset();
      test_shadow_commit();
      test_sweep();
      test_ovf();
      test_abort();
      test_commit_busy();
      test_nut_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
